uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with SAMPLE_AMT-times oversampling, midpoint bit sampling,
// framing-error detection and break hold-off.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int SAMPLE_AMT = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rx_en,
    input  logic                  baud,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_done,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int CNT_W = (SAMPLE_AMT > 2) ? $clog2(SAMPLE_AMT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SAMPLE_AMT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_AMT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  rx_sync_p0;
    logic                  rx_sync_p1;
    logic                  rx_s;

    // Stage boundary: pad -> two-flop synchronizer, idles high out of reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rx_s = rx_sync_p1;

    // Data path only; its contents matter only once a full frame has shifted in
    always_ff @(posedge clk) begin
        if (state == S_DATA && baud && cnt == CNT_LAST) begin
            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_en && !rx_s) begin
                        state   <= S_START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud) begin
                        if (cnt == CNT_MID) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state   <= S_DATA;
                                bit_idx <= '0;
                            end else begin
                                state   <= S_IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (baud) begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (bit_idx == IDX_LAST) begin
                                state <= S_STOP;
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (baud) begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            rx_data <= shreg;
                            if (rx_s) begin
                                rx_done <= 1'b1;
                                state   <= S_IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                // A line held low after a bad stop bit must not start new frames
                S_BREAK: begin
                    if (rx_s) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    bit_idx <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, randomized frames against a frame-level
// reference model, and hand sequences for false start, break, reset and rx_en.
module tb_uart_rx;

    localparam int DW   = 8;
    localparam int SA   = 16;
    localparam int SPAN = SA / 2 + SA * (DW + 1);

    logic          clk;
    logic          resetn;
    logic          rx_en;
    logic          baud;
    logic          rx;
    logic [DW-1:0] rx_data;
    logic          rx_done;
    logic          frame_err;
    logic          rx_busy;

    uart_rx #(.DATA_WIDTH(DW), .SAMPLE_AMT(SA)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx_en    (rx_en),
        .baud     (baud),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] done_q[$];
    int            err_cnt   = 0;
    int            tick_cnt  = 0;
    int            last_busy = 0;
    bit            prev_done = 0;
    bit            busy_seen = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          stop;
        logic [DW-1:0] exp_data;
        logic          exp_done;
        logic          exp_err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock baud tick every 4 clocks, changed just after the rising edge
    initial begin
        int phase;
        phase = 0;
        baud  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 4;
            baud  = (phase == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            tick_cnt  = 0;
            prev_done = 0;
        end else begin
            if (rx_busy) busy_seen = 1;
            if (rx_done) begin
                done_q.push_back(rx_data);
                chk("pulse_exclusive", frame_err, 0);
                chk("done_width", prev_done, 0);
                chk("done_span_ticks", tick_cnt, SPAN);
            end
            if (frame_err) begin
                err_cnt++;
                chk("err_span_ticks", tick_cnt, SPAN);
            end
            prev_done = rx_done;
            if (!rx_busy) begin
                if (tick_cnt != 0) last_busy = tick_cnt;
                tick_cnt = 0;
            end else if (baud) begin
                tick_cnt++;
            end
        end
    end

    // Returns 2 time units after the edge that consumed the n-th tick
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!baud);
        end
        #2;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input bit drop_en);
        rx = 1'b0;
        wait_ticks(SA);
        if (drop_en) rx_en = 1'b0;
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            wait_ticks(SA);
        end
        rx = stop;
        wait_ticks(SA);
    endtask

    // Frame-level reference: the byte is delivered, stop bit decides done vs error
    function automatic void ref_model(input logic [DW-1:0] d, input logic stop,
                                      output logic [DW-1:0] ed, output logic edn,
                                      output logic eer);
        ed  = d;
        edn = stop;
        eer = ~stop;
    endfunction

    task automatic run_frame(input logic [DW-1:0] d, input logic stop, input bit drop_en,
                             input logic [DW-1:0] ed, input logic edn, input logic eer,
                             input string tag);
        int q0, e0;
        q0 = done_q.size();
        e0 = err_cnt;
        send_frame(d, stop, drop_en);
        if (!stop) begin
            rx = 1'b1;
            wait_ticks(3);
        end
        chk({tag, "_done_cnt"}, done_q.size() - q0, {31'd0, edn});
        chk({tag, "_err_cnt"}, err_cnt - e0, {31'd0, eer});
        if (done_q.size() > q0) chk({tag, "_done_data"}, done_q[$], ed);
        chk({tag, "_rx_data"}, rx_data, ed);
        chk({tag, "_busy_after"}, rx_busy, 0);
    endtask

    initial begin
        int q0, e0;
        logic [DW-1:0] ed, rd;
        logic edn, eer, st;

        tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b0};
        tbl[5] = '{8'hC3, 1'b0, 8'hC3, 1'b0, 1'b1};
        tbl[6] = '{8'h55, 1'b1, 8'h55, 1'b1, 1'b0};

        resetn = 1'b0;
        rx     = 1'b1;
        rx_en  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_done", rx_done, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_rx_busy", rx_busy, 0);
        #1 resetn = 1'b1;
        rx_en = 1'b1;
        wait_ticks(4);

        for (int i = 0; i < 7; i++)
            run_frame(tbl[i].data, tbl[i].stop, 0, tbl[i].exp_data,
                      tbl[i].exp_done, tbl[i].exp_err, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            rd = DW'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) != 0);
            ref_model(rd, st, ed, edn, eer);
            run_frame(rd, st, 0, ed, edn, eer, $sformatf("rand%0d", i));
            wait_ticks($urandom_range(0, 5));
        end

        // False start: short low pulse is rejected at the start-bit midpoint
        run_frame(8'h96, 1'b1, 0, 8'h96, 1'b1, 1'b0, "pre_false");
        q0 = done_q.size();
        e0 = err_cnt;
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(12);
        chk("false_done_cnt", done_q.size() - q0, 0);
        chk("false_err_cnt", err_cnt - e0, 0);
        chk("false_rx_data", rx_data, 8'h96);
        chk("false_busy", rx_busy, 0);
        chk("false_busy_ticks", last_busy, SA / 2);

        // Framing error followed by a held-low line
        q0 = done_q.size();
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 0);
        wait_ticks(40);
        chk("brk_err_cnt", err_cnt - e0, 1);
        chk("brk_done_cnt", done_q.size() - q0, 0);
        chk("brk_rx_data", rx_data, 8'h3C);
        chk("brk_busy_held", rx_busy, 1);
        rx = 1'b1;
        wait_ticks(3);
        chk("brk_busy_release", rx_busy, 0);
        chk("brk_err_cnt_after", err_cnt - e0, 1);
        run_frame(8'h5A, 1'b1, 0, 8'h5A, 1'b1, 1'b0, "post_brk");

        // Back-to-back frames with no idle time
        q0 = done_q.size();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        wait_ticks(2);
        chk("b2b_done_cnt", done_q.size() - q0, 2);
        if (done_q.size() >= q0 + 2) begin
            chk("b2b_first", done_q[q0], 8'h00);
            chk("b2b_second", done_q[q0+1], 8'hFF);
        end

        // rx_en low for a whole frame: nothing happens
        rx_en = 1'b0;
        wait_ticks(1);
        busy_seen = 0;
        q0 = done_q.size();
        e0 = err_cnt;
        send_frame(8'h77, 1'b1, 0);
        wait_ticks(4);
        chk("en_off_busy_seen", busy_seen, 0);
        chk("en_off_done_cnt", done_q.size() - q0, 0);
        chk("en_off_err_cnt", err_cnt - e0, 0);
        chk("en_off_rx_data", rx_data, 8'hFF);

        // rx_en dropped after the start bit: frame still completes
        rx_en = 1'b1;
        wait_ticks(2);
        run_frame(8'h3E, 1'b1, 1, 8'h3E, 1'b1, 1'b0, "en_drop");
        rx_en = 1'b1;
        wait_ticks(2);

        // Reset asserted during data bit 3
        rx = 1'b0;
        wait_ticks(SA);
        rx = 1'b1;
        wait_ticks(3 * SA + SA / 2);
        chk("mid_busy_before", rx_busy, 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_done", rx_done, 0);
        chk("mid_rst_frame_err", frame_err, 0);
        chk("mid_rst_rx_busy", rx_busy, 0);
        @(posedge clk);
        #3 resetn = 1'b1;
        busy_seen = 0;
        q0 = done_q.size();
        e0 = err_cnt;
        wait_ticks(200);
        chk("post_rst_done_cnt", done_q.size() - q0, 0);
        chk("post_rst_err_cnt", err_cnt - e0, 0);
        chk("post_rst_busy_seen", busy_seen, 0);
        chk("post_rst_rx_data", rx_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
